// File: rtl/regfile_wb_arbiter.sv
// Two-requester writeback arbiter with a register busy scoreboard; optional contention counter under WB_ARB_STATS_EN.
// Latency: ready is combinational; the accepted write appears on rf_we/rf_waddr/rf_wdata one cycle after acceptance.
// Backpressure: one requester gets ready per cycle (round-robin on contention); stall or rst withholds all readies.
module regfile_wb_arbiter (
    input  logic        CLK,
    input  logic        rst,
    input  logic        a_valid,
    input  logic [4:0]  a_addr,
    input  logic [31:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [4:0]  b_addr,
    input  logic [31:0] b_data,
    output logic        b_ready,
    input  logic        stall,
    input  logic        rsv_valid,
    input  logic [4:0]  rsv_addr,
    output logic [31:0] busy,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [15:0] conflict_cnt
);

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_req_t;

    logic    last_b;
    logic    grant_a;
    logic    grant_b;
    logic    acc;
    wb_req_t acc_req;
    logic [31:0] busy_nxt;

    // On contention the requester that did not win last time goes first.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!rst && !stall) begin
            grant_a = a_valid && (!b_valid || last_b);
            grant_b = b_valid && (!a_valid || !last_b);
        end
    end

    assign a_ready = grant_a;
    assign b_ready = grant_b;
    assign acc     = grant_a || grant_b;

    always_comb begin
        acc_req = grant_b ? wb_req_t'{addr: b_addr, data: b_data}
                          : wb_req_t'{addr: a_addr, data: a_data};
    end

    // Reservation is applied after the writeback clear so a same-cycle reserve wins.
    always_comb begin
        busy_nxt = busy;
        if (acc)
            busy_nxt[acc_req.addr] = 1'b0;
        if (rsv_valid)
            busy_nxt[rsv_addr] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            last_b   <= 1'b1;
            busy     <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            busy  <= busy_nxt;
            rf_we <= acc && (acc_req.addr != 5'd0);
            if (acc) begin
                last_b   <= grant_b;
                rf_waddr <= acc_req.addr;
                rf_wdata <= acc_req.data;
            end
        end
    end

`ifdef WB_ARB_STATS_EN
    logic [15:0] conflict_q;

    always_ff @(posedge CLK) begin
        if (rst)
            conflict_q <= '0;
        else if (a_valid && b_valid && !stall && conflict_q != 16'hFFFF)
            conflict_q <= conflict_q + 16'd1;
    end

    assign conflict_cnt = conflict_q;
`else
    assign conflict_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: table-driven ready checks, writeback scoreboard, busy and contention models.
module tb_regfile_wb_arbiter;

    logic        CLK = 1'b0;
    logic        rst = 1'b1;
    logic        a_valid = 1'b0, b_valid = 1'b0, stall = 1'b0, rsv_valid = 1'b0;
    logic [4:0]  a_addr = '0, b_addr = '0, rsv_addr = '0;
    logic [31:0] a_data = '0, b_data = '0;
    logic        a_ready, b_ready, rf_we;
    logic [31:0] busy, rf_wdata;
    logic [4:0]  rf_waddr;
    logic [15:0] conflict_cnt;

    regfile_wb_arbiter dut (
        .CLK(CLK), .rst(rst),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .stall(stall), .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
        .busy(busy), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .conflict_cnt(conflict_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        bv;
        logic [4:0]  ba;
        logic [31:0] bd;
        logic        st;
        logic        rv;
        logic [4:0]  ra;
        logic        ea;
        logic        eb;
    } vec_t;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         sb[$];
    logic [31:0] busy_m;
    logic [15:0] cnt_m;
    int          tests = 0;
    int          fails = 0;

    function automatic vec_t mk(int av, int aa, int ad, int bv, int ba, int bd,
                                int st, int rv, int ra, int ea, int eb);
        vec_t v;
        v.av = 1'(av); v.aa = 5'(aa); v.ad = 32'(ad);
        v.bv = 1'(bv); v.ba = 5'(ba); v.bd = 32'(bd);
        v.st = 1'(st); v.rv = 1'(rv); v.ra = 5'(ra);
        v.ea = 1'(ea); v.eb = 1'(eb);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_wb();
        wr_t w;
        if (sb.size() > 0) begin
            w = sb.pop_front();
            chk("rf_we", 32'(rf_we), 32'd1);
            chk("rf_waddr", 32'(rf_waddr), 32'(w.addr));
            chk("rf_wdata", rf_wdata, w.data);
        end else begin
            chk("rf_we_idle", 32'(rf_we), 32'd0);
        end
    endtask

    task automatic step(input vec_t v);
        rst = 1'b0;
        a_valid = v.av; a_addr = v.aa; a_data = v.ad;
        b_valid = v.bv; b_addr = v.ba; b_data = v.bd;
        stall = v.st; rsv_valid = v.rv; rsv_addr = v.ra;
        @(negedge CLK);
        chk("a_ready", 32'(a_ready), 32'(v.ea));
        chk("b_ready", 32'(b_ready), 32'(v.eb));
        if (v.ea) begin
            if (v.aa != 5'd0) sb.push_back('{addr: v.aa, data: v.ad});
            busy_m[v.aa] = 1'b0;
        end else if (v.eb) begin
            if (v.ba != 5'd0) sb.push_back('{addr: v.ba, data: v.bd});
            busy_m[v.ba] = 1'b0;
        end
        if (v.rv) busy_m[v.ra] = 1'b1;
        busy_m[0] = 1'b0;
`ifdef WB_ARB_STATS_EN
        if (v.av && v.bv && !v.st && cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
`endif
        @(posedge CLK); #1;
        check_wb();
        chk("busy", busy, busy_m);
        chk("conflict_cnt", 32'(conflict_cnt), 32'(cnt_m));
    endtask

    // A request is presented during reset to confirm it is never accepted.
    task automatic do_reset();
        rst = 1'b1;
        a_valid = 1'b1; a_addr = 5'd3; a_data = 32'hDEAD;
        b_valid = 1'b0; stall = 1'b0; rsv_valid = 1'b0;
        @(negedge CLK);
        chk("rst_a_ready", 32'(a_ready), 32'd0);
        chk("rst_b_ready", 32'(b_ready), 32'd0);
        @(posedge CLK); #1;
        rst = 1'b0; a_valid = 1'b0;
        sb.delete();
        busy_m = '0;
        cnt_m = '0;
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_rf_waddr", 32'(rf_waddr), 32'd0);
        chk("rst_rf_wdata", rf_wdata, 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_conflict", 32'(conflict_cnt), 32'd0);
    endtask

    vec_t tbl[13];
    vec_t both;

    initial begin
        // av aa ad        bv ba bd        st rv ra  ea eb
        tbl[0]  = mk(1, 5, 'h1234, 0, 0, 0,      0, 0, 0,  1, 0);
        tbl[1]  = mk(0, 0, 0,      1, 3, 'hB003, 0, 1, 12, 0, 1);
        tbl[2]  = mk(1, 4, 'hA004, 1, 6, 'hB006, 0, 0, 0,  1, 0);
        tbl[3]  = mk(1, 4, 'hA014, 1, 6, 'hB016, 0, 0, 0,  0, 1);
        tbl[4]  = mk(0, 0, 0,      0, 0, 0,      0, 1, 7,  0, 0);
        tbl[5]  = mk(1, 8, 'hA008, 1, 9, 'hB009, 1, 0, 0,  0, 0);
        tbl[6]  = mk(1, 8, 'hA008, 1, 9, 'hB009, 0, 0, 0,  1, 0);
        tbl[7]  = mk(1, 7, 'hA007, 0, 0, 0,      0, 0, 0,  1, 0);
        tbl[8]  = mk(1, 12,'hA00C, 0, 0, 0,      0, 0, 0,  1, 0);
        tbl[9]  = mk(1, 1, 'hA001, 1, 2, 'hB002, 0, 0, 0,  0, 1);
        tbl[10] = mk(1, 0, 'hA000, 0, 0, 0,      0, 1, 0,  1, 0);
        tbl[11] = mk(0, 0, 0,      1, 5, 'hB005, 1, 0, 0,  0, 0);
        tbl[12] = mk(0, 0, 0,      1, 5, 'hB005, 0, 0, 0,  0, 1);

        busy_m = '0;
        cnt_m = '0;
        do_reset();
        for (int i = 0; i < 13; i++) step(tbl[i]);

        // Contention straight after reset alternates starting with A.
        do_reset();
        both = mk(1, 10, 'hA00A, 1, 11, 'hB00B, 0, 0, 0, 1, 0);
        step(both);
        both.ea = 1'b0; both.eb = 1'b1; step(both);
        both.ea = 1'b1; both.eb = 1'b0; step(both);
        both.ea = 1'b0; both.eb = 1'b1; step(both);
`ifdef WB_ARB_STATS_EN
        chk("conflict_after_4", 32'(conflict_cnt), 32'd4);
`else
        chk("conflict_after_4", 32'(conflict_cnt), 32'd0);
`endif

        // Reserve 7, idle, then write 7.
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0));
        chk("busy7_set", 32'(busy[7]), 32'd1);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step(mk(1, 7, 'h7777, 0, 0, 0, 0, 0, 0, 1, 0));
        chk("busy7_clr", 32'(busy[7]), 32'd0);

        // Same-cycle reserve and write to 9 keeps it busy.
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0));
        step(mk(1, 9, 'h9999, 0, 0, 0, 0, 1, 9, 1, 0));
        chk("busy9_held", 32'(busy[9]), 32'd1);

        // Stall holds A off, then reset discards it.
        for (int i = 0; i < 3; i++) step(mk(1, 6, 'h6666, 0, 0, 0, 1, 0, 0, 0, 0));
        do_reset();
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
